// File: rtl/regfile_master_if.sv
// Request/response handshake bundle between an upstream requester
// and the register-file controller.
interface regfile_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ovf;
    logic              busy;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        output req_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_ovf,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        input  req_data,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_ovf,
        output busy
    );
endinterface

// File: rtl/regfile_master.sv
// Initiator-side controller for a single-port register file:
// READ, WRITE, read-add-write and block FILL over a valid/ready handshake.
module regfile_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    regfile_master_if.slave   bus,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rf_we_,
    input  logic [DATA_W-1:0] rf_d_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FILL = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_carry;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_ovf;

    logic              w_accept;
    logic              w_last;
    logic [DATA_W:0]   w_sum;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    // FILL stops at the top of the array; the pointer never wraps
    assign w_last   = &r_addr;
    assign w_sum    = {1'b0, rf_d_out} + {1'b0, r_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (1'b1)
                        (bus.req_op == OP_READ),
                        (bus.req_op == OP_ADD):   w_next = S_RD;
                        (bus.req_op == OP_WRITE): w_next = S_WR;
                        default:                  w_next = S_FILL;
                    endcase
                end
            end
            S_RD: begin
                w_next = (r_op == OP_ADD) ? S_WR : S_IDLE;
            end
            S_WR: begin
                w_next = S_IDLE;
            end
            S_FILL: begin
                w_next = w_last ? S_IDLE : S_FILL;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Array strobes come only from registered state, address and data
    always_comb begin
        bus.req_ready = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
        rf_we_        = !((r_state == S_WR) || (r_state == S_FILL));
        rf_addr       = r_addr;
        rf_d_in       = r_data;
        bus.rsp_valid = r_rsp_valid;
        bus.rsp_data  = r_rsp_data;
        bus.rsp_ovf   = r_rsp_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_data      <= '0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_ovf   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.req_op;
                        r_addr  <= bus.req_addr;
                        r_data  <= bus.req_data;
                        r_carry <= 1'b0;
                    end
                end
                S_RD: begin
                    if (r_op == OP_ADD) begin
                        // r_data now holds the sum that WR will commit
                        {r_carry, r_data} <= w_sum;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= rf_d_out;
                        r_rsp_ovf   <= 1'b0;
                    end
                end
                S_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_data;
                    r_rsp_ovf   <= r_carry;
                end
                S_FILL: begin
                    if (w_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_data;
                        r_rsp_ovf   <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_master.sv
// Self-checking bench for regfile_master: directed vector table,
// hand-written corner sequences and randomized traffic vs. a reference model.
module tb_regfile_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_d_in;
    logic          rf_we_;
    logic [DW-1:0] rf_d_out;

    regfile_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .rf_addr  (rf_addr),
        .rf_d_in  (rf_d_in),
        .rf_we_   (rf_we_),
        .rf_d_out (rf_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file instance the controller drives
    logic [DW-1:0] rf_mem [DEPTH];
    logic          preload;
    int            cyc;
    int            wl_addr[$];
    int            wl_cyc[$];

    assign rf_d_out = rf_mem[rf_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < DEPTH; i++)
                rf_mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (!rf_we_) begin
            rf_mem[rf_addr] <= rf_d_in;
            wl_addr.push_back(int'(rf_addr));
            wl_cyc.push_back(cyc);
        end
    end

    // Reference model: array contents plus per-op result and latency
    logic [DW-1:0] ref_mem [DEPTH];

    task automatic model(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] ed,
                         output logic eo, output int el);
        logic [DW:0] s;
        eo = 1'b0;
        case (op)
            OP_READ: begin
                ed = ref_mem[a];
                el = 2;
            end
            OP_WRITE: begin
                ref_mem[a] = d;
                ed = d;
                el = 2;
            end
            OP_ADD: begin
                s = {1'b0, ref_mem[a]} + {1'b0, d};
                ref_mem[a] = s[DW-1:0];
                ed = s[DW-1:0];
                eo = s[DW];
                el = 3;
            end
            default: begin
                for (int i = int'(a); i < DEPTH; i++)
                    ref_mem[i] = d;
                ed = d;
                el = DEPTH - int'(a) + 1;
            end
        endcase
    endtask

    int n_pass;
    int n_total;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        else
            n_pass++;
    endtask

    // Issue one request; lat counts cycles from acceptance to rsp_valid
    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd,
                          output logic ro, output int lat);
        rd  = '0;
        ro  = 1'b0;
        lat = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_data  = d;
        wl_addr.delete();
        wl_cyc.delete();
        for (int k = 0; k < 100 && !bus.req_ready; k++)
            @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.rsp_valid) begin
                lat = n;
                rd  = bus.rsp_data;
                ro  = bus.rsp_ovf;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_d;
        logic          exp_o;
        int            exp_lat;
        int            exp_wr;
    } vec_t;

    vec_t tbl[15];

    logic [DW-1:0] rd;
    logic          ro;
    int            lat;
    logic [DW-1:0] ed;
    logic          eo;
    int            el;
    bit            ok;
    logic [1:0]    rop;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    initial begin
        tbl[0]  = '{OP_WRITE, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2,  1};
        tbl[1]  = '{OP_READ,  5'd3,  32'h0,        32'hDEADBEEF, 1'b0, 2,  0};
        tbl[2]  = '{OP_WRITE, 5'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2,  1};
        tbl[3]  = '{OP_ADD,   5'd7,  32'h1,        32'h0,        1'b1, 3,  1};
        tbl[4]  = '{OP_READ,  5'd7,  32'h0,        32'h0,        1'b0, 2,  0};
        tbl[5]  = '{OP_ADD,   5'd5,  32'h10,       32'h10000015, 1'b0, 3,  1};
        tbl[6]  = '{OP_FILL,  5'd28, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 5,  4};
        tbl[7]  = '{OP_READ,  5'd27, 32'h0,        32'h1000001B, 1'b0, 2,  0};
        tbl[8]  = '{OP_READ,  5'd28, 32'h0,        32'hA5A5A5A5, 1'b0, 2,  0};
        tbl[9]  = '{OP_FILL,  5'd31, 32'h12345678, 32'h12345678, 1'b0, 2,  1};
        tbl[10] = '{OP_READ,  5'd31, 32'h0,        32'h12345678, 1'b0, 2,  0};
        tbl[11] = '{OP_READ,  5'd30, 32'h0,        32'hA5A5A5A5, 1'b0, 2,  0};
        tbl[12] = '{OP_FILL,  5'd0,  32'h5A5A0000, 32'h5A5A0000, 1'b0, 33, 32};
        tbl[13] = '{OP_READ,  5'd0,  32'h0,        32'h5A5A0000, 1'b0, 2,  0};
        tbl[14] = '{OP_READ,  5'd31, 32'h0,        32'h5A5A0000, 1'b0, 2,  0};

        n_pass = 0;
        n_total = 0;
        cyc = 0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_READ;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < DEPTH; i++)
            ref_mem[i] = 32'h1000_0000 + 32'(i);

        preload = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ready",  64'(bus.req_ready), 64'd1);
        chk("rst_busy",   64'(bus.busy),      64'd0);
        chk("rst_we",     64'(rf_we_),        64'd1);
        chk("rst_addr",   64'(rf_addr),       64'd0);
        chk("rst_din",    64'(rf_d_in),       64'd0);
        chk("rst_rspv",   64'(bus.rsp_valid), 64'd0);
        chk("rst_rspd",   64'(bus.rsp_data),  64'd0);
        chk("rst_ovf",    64'(bus.rsp_ovf),   64'd0);

        // Directed vectors
        for (int v = 0; v < 15; v++) begin
            do_req(tbl[v].op, tbl[v].addr, tbl[v].data, rd, ro, lat);
            model(tbl[v].op, tbl[v].addr, tbl[v].data, ed, eo, el);
            chk($sformatf("vec%0d_data", v), 64'(rd),  64'(tbl[v].exp_d));
            chk($sformatf("vec%0d_ovf", v),  64'(ro),  64'(tbl[v].exp_o));
            chk($sformatf("vec%0d_lat", v),  64'(lat), 64'(tbl[v].exp_lat));
            ok = (wl_addr.size() == tbl[v].exp_wr);
            for (int i = 0; ok && i < wl_addr.size(); i++)
                ok = (wl_addr[i] == int'(tbl[v].addr) + i) &&
                     (wl_cyc[i] == wl_cyc[0] + i);
            chk($sformatf("vec%0d_wrseq", v), 64'(ok), 64'd1);
        end

        // Held request while busy, then a request taken in the response cycle
        wl_addr.delete();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_READ;
        bus.req_addr  = 5'd3;
        model(OP_READ, 5'd3, 32'h0, ed, eo, el);
        @(negedge clk);
        chk("hold_busy",  64'(bus.busy),      64'd1);
        chk("hold_ready", 64'(bus.req_ready), 64'd0);
        chk("hold_we",    64'(rf_we_),        64'd1);
        bus.req_op   = OP_FILL;
        bus.req_addr = 5'd0;
        @(negedge clk);
        chk("hold_rspv", 64'(bus.rsp_valid), 64'd1);
        chk("hold_rspd", 64'(bus.rsp_data),  64'(ed));
        bus.req_op   = OP_WRITE;
        bus.req_addr = 5'd9;
        bus.req_data = 32'h77;
        model(OP_WRITE, 5'd9, 32'h77, ed, eo, el);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_norsp", 64'(bus.rsp_valid), 64'd0);
        chk("b2b_we",    64'(rf_we_),        64'd0);
        chk("b2b_addr",  64'(rf_addr),       64'd9);
        @(negedge clk);
        chk("b2b_rspv",  64'(bus.rsp_valid), 64'd1);
        chk("b2b_rspd",  64'(bus.rsp_data),  64'h77);
        chk("b2b_nwr",   64'(wl_addr.size()), 64'd1);

        // Reset during cycle 10 of a FILL from address 0
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_FILL;
        bus.req_addr  = 5'd0;
        bus.req_data  = 32'hC0FFEE00;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we",    64'(rf_we_),        64'd1);
        chk("arst_addr",  64'(rf_addr),       64'd0);
        chk("arst_din",   64'(rf_d_in),       64'd0);
        chk("arst_busy",  64'(bus.busy),      64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd1);
        chk("arst_rspv",  64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) ok = 1'b0;
        end
        chk("arst_norsp", 64'(ok), 64'd1);
        for (int i = 0; i <= 8; i++)
            ref_mem[i] = 32'hC0FFEE00;
        for (int i = 0; i < DEPTH; i++) begin
            do_req(OP_READ, AW'(i), 32'h0, rd, ro, lat);
            model(OP_READ, AW'(i), 32'h0, ed, eo, el);
            chk($sformatf("partial_%0d", i), 64'(rd), 64'(ed));
        end

        // Randomized traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            rop   = 2'($urandom_range(0, 3));
            raddr = AW'($urandom);
            rdata = $urandom;
            if (rop == OP_FILL)
                raddr = AW'($urandom_range(20, 31));
            if (rop == OP_ADD && $urandom_range(0, 1) == 1)
                rdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            do_req(rop, raddr, rdata, rd, ro, lat);
            model(rop, raddr, rdata, ed, eo, el);
            chk($sformatf("rnd%0d_data", t), 64'(rd),  64'(ed));
            chk($sformatf("rnd%0d_ovf", t),  64'(ro),  64'(eo));
            chk($sformatf("rnd%0d_lat", t),  64'(lat), 64'(el));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Response is a single-cycle pulse
    logic prev_rspv;
    always @(posedge clk) begin
        if (!reset && prev_rspv && bus.rsp_valid)
            chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
        prev_rspv <= bus.rsp_valid;
    end

endmodule

// File: doc/regfile_master.md
# regfile_master

Initiator-side controller for the single-port register file: accepts command requests over a valid/ready handshake, sequences the register file's address, write-data and active-low write-enable lines, and samples its combinational read data. It supports single read, single write, read-add-write, and block fill, so that upstream logic never drives the array directly. It sits between the datapath or debug port and one register-file instance, sharing that instance's clock.

## Interface
- ADDR_W, 5: register-file address width; depth DATA_D = 2**ADDR_W.
- DATA_W, 32: register-file data width.

- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_op  input  2  00 READ, 01 WRITE, 10 ADD (read-add-write), 11 FILL.
- req_addr  input  ADDR_W  target address; FILL start address.
- req_data  input  DATA_W  write data, addend, or fill value.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_data  output  DATA_W  READ: value read; WRITE/FILL: value written; ADD: new sum.
- rsp_ovf  output  1  ADD carry-out; 0 for other ops.
- busy  output  1  operation in progress (state not IDLE).
- rf_addr  output  ADDR_W  register-file address.
- rf_d_in  output  DATA_W  register-file write data.
- rf_we_  output  1  register-file write enable, active-low.
- rf_d_out  input  DATA_W  register-file combinational read data.

## Operation
- States: IDLE, RD, WR, FILL.
- rf_addr, rf_d_in, rf_we_ are decoded only from registered state, address, and data, so they are glitch-free.
- Command fields are captured on acceptance, meaning the edge where req_valid && req_ready.
- req_ready = (state == IDLE). Requests presented while busy are ignored; the requester must hold them.
- IDLE: rf_we_ = 1. On acceptance:
  - READ goes to RD.
  - ADD goes to RD.
  - WRITE goes to WR.
  - FILL goes to FILL with the pointer set to req_addr.
- RD: rf_addr = captured address, rf_we_ = 1.
  - READ: latch rsp_data = rf_d_out, pulse rsp_valid, return to IDLE.
  - ADD: compute {carry, sum} = rf_d_out + data as a DATA_W+1-bit sum, latch it, go to WR.
- WR: rf_addr = captured address, rf_d_in = data (or the sum for ADD), rf_we_ = 0 for exactly this cycle. Then pulse rsp_valid with rsp_data = value written and rsp_ovf = carry (ADD only), and return to IDLE.
- FILL: rf_we_ = 0, rf_addr = pointer, rf_d_in = fill value. Each cycle the pointer increments by 1.
  - When the pointer equals DATA_D-1, that write is the last one. Then pulse rsp_valid with rsp_data = fill value and return to IDLE.
  - The pointer never wraps. A FILL starting at DATA_D-1 performs exactly one write.
- ADD arithmetic wraps modulo 2**DATA_W. rsp_ovf carries the bit that was shed.
- Reset (asynchronous, any state) forces:
  - state = IDLE, so busy = 0 and req_ready = 1.
  - rf_we_ = 1, rf_addr = 0, rf_d_in = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_ovf = 0.
  - An operation in flight is abandoned with no response. Writes already committed remain; a FILL interrupted mid-way leaves a partial fill.

## Timing
- Request accepted at edge of cycle T. rsp_valid is high for one cycle and req_ready returns to 1 in the same cycle.
- READ: RD in T+1; rsp_valid in T+2.
- WRITE: WR in T+1 (array updated at end of T+1); rsp_valid in T+2.
- ADD: RD in T+1, WR in T+2; rsp_valid in T+3.
- FILL from start address S: N = DATA_D − S writes in cycles T+1..T+N; rsp_valid in T+N+1.
- A new request can be accepted in the response cycle. Back-to-back READs therefore run every 2 cycles.
- Read-after-write across requests returns the new value, because the write commits before the next RD cycle.
- rsp_valid never asserts in two consecutive cycles.

## Test plan
- Reset then WRITE addr 3 data 0xDEADBEEF, then READ addr 3 -> rf_we_ low for exactly 1 cycle with rf_addr=3. READ rsp_valid 2 cycles after acceptance with rsp_data=0xDEADBEEF.
- ADD addr 7 data 1 with ff[7]=0xFFFFFFFF -> rsp_data=0, rsp_ovf=1 at T+3; a following READ of 7 returns 0.
- FILL addr 28 data 0xA5A5A5A5 (ADDR_W=5) -> 4 consecutive write cycles at addresses 28..31, rsp_valid at T+5, req_ready low T+1..T+4; READs of 27 and 28 return the old value and 0xA5A5A5A5 respectively.
- FILL addr 31 -> single write, rsp_valid at T+2. FILL addr 0 -> 32 writes, rsp_valid at T+33, no pointer wrap.
- req_valid held during busy with a changing req_op -> ignored until IDLE. A request presented in the rsp_valid cycle is accepted and its response arrives 2 cycles later.
- Assert reset during cycle 10 of FILL from 0 -> outputs immediately return to reset values, no rsp_valid; addresses 0..8 hold the fill value and the rest keep their prior contents.
